// File: rtl/debug_trace_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// debug_trace_arbiter_pkg
//   Shared definitions for the debug/trace arbiter: register map offsets,
//   CTRL/STATUS bit positions, drop-counter width and the bus address decoder.
// -----------------------------------------------------------------------------
package debug_trace_arbiter_pkg;

   localparam int DATA_W = 32;   // trace word width
   localparam int DROP_W = 16;   // saturating drop counter width

   // Register byte offsets within the block
   localparam logic [7:0] ADDR_CTRL   = 8'h00;
   localparam logic [7:0] ADDR_STATUS = 8'h04;
   localparam logic [7:0] ADDR_DROP   = 8'h08;
   localparam logic [7:0] ADDR_LAST   = 8'h0C;
   localparam logic [7:0] ADDR_PUSH   = 8'h10;

   // CTRL fields
   localparam int CTRL_EN_BIT    = 0;
   localparam int CTRL_FLUSH_BIT = 1;
   localparam int CTRL_MASK_LSB  = 8;

   // STATUS fields
   localparam int STAT_EMPTY_BIT = 0;
   localparam int STAT_FULL_BIT  = 1;
   localparam int STAT_OVF_BIT   = 2;
   localparam int STAT_CNT_LSB   = 8;

   typedef enum logic [2:0] {
      REG_CTRL,
      REG_STATUS,
      REG_DROP,
      REG_LAST,
      REG_PUSH,
      REG_NONE
   } reg_sel_e;

   // Exact-offset decode; anything else maps to REG_NONE (reads 0, writes ignored).
   function automatic reg_sel_e decode_addr(input logic [7:0] addr);
      reg_sel_e sel;
      case (addr)
         ADDR_CTRL:   sel = REG_CTRL;
         ADDR_STATUS: sel = REG_STATUS;
         ADDR_DROP:   sel = REG_DROP;
         ADDR_LAST:   sel = REG_LAST;
         ADDR_PUSH:   sel = REG_PUSH;
         default:     sel = REG_NONE;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/debug_trace_fifo.sv
// -----------------------------------------------------------------------------
// debug_trace_fifo
//   First-word fall-through FIFO. The head entry is presented on head_data
//   whenever the FIFO is not empty; pop advances to the next entry.
//   DEPTH must be a power of two (pointers wrap by natural overflow).
// Ports
//   clk, rst_n  clock, asynchronous active-low reset
//   flush       clear pointers/count this cycle; push and pop are ignored
//   push        write push_data (ignored while full, judged on registered count)
//   push_data   entry to write
//   pop         advance the read pointer (ignored while empty)
//   head_data   entry at the read pointer
//   count       number of stored entries (0..DEPTH)
//   full/empty  derived from the registered count
// -----------------------------------------------------------------------------
module debug_trace_fifo #(
   parameter int WIDTH = 35,
   parameter int DEPTH = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    flush,
   input  logic                    push,
   input  logic [WIDTH-1:0]        push_data,
   input  logic                    pop,
   output logic [WIDTH-1:0]        head_data,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    full,
   output logic                    empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign full      = (count_q == CW'(DEPTH));
   assign empty     = (count_q == '0);
   assign count     = count_q;
   assign head_data = mem_q[rd_ptr_q];

   // Full is taken from the registered count, so a same-cycle pop never makes room.
   assign do_push = push & ~full & ~flush;
   assign do_pop  = pop & ~empty & ~flush;

   always_comb begin
      // NOTE: every always_comb target is given a default first so no path leaves it
      // unassigned; a missing default would infer a latch.
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   // NOTE: state flops use non-blocking assignments so every flop samples the
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: the storage array has no reset; entries are only observable once
   // written, and the head output is masked by the consumer while empty.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/debug_trace_arbiter.sv
// -----------------------------------------------------------------------------
// debug_trace_arbiter
//   Shares a 32-bit trace channel between NUM_REQ hardware requesters and CPU
//   bus writes. A round-robin arbiter admits at most one word per cycle into a
//   source-tagged FWFT FIFO that drains to a valid/ready trace sink. A small
//   memory-mapped register file provides control, status, a saturating drop
//   counter, the last accepted word and a CPU push port.
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   address           bus byte offset
//   write_data        bus write data
//   read_data         bus read data, combinational from address
//   we, re            bus write strobe (one cycle) / read strobe (no side effects)
//   req_valid         per-requester word available
//   req_data          requester i word at [32*i +: 32]
//   req_ready         one-hot grant
//   trace_valid       FIFO head valid
//   trace_data        FIFO head word
//   trace_src         FIFO head source ID (CPU = NUM_REQ)
//   trace_ready       sink accepts the head
//   irq_overflow      sticky overflow flag
// -----------------------------------------------------------------------------
module debug_trace_arbiter
   import debug_trace_arbiter_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int FIFO_DEPTH = 8,
   parameter int SRC_W      = 3
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [7:0]                address,
   input  logic [DATA_W-1:0]         write_data,
   output logic [DATA_W-1:0]         read_data,
   input  logic                      we,
   input  logic                      re,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [DATA_W*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      trace_valid,
   output logic [DATA_W-1:0]         trace_data,
   output logic [SRC_W-1:0]          trace_src,
   input  logic                      trace_ready,
   output logic                      irq_overflow
);

   localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int PW1     = PTR_W + 1;
   localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
   localparam int ENTRY_W = SRC_W + DATA_W;
   localparam logic [PTR_W:0]   NREQ_W   = PW1'(NUM_REQ);
   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);
   localparam logic [SRC_W-1:0] CPU_SRC  = SRC_W'(NUM_REQ);

   // Registered state
   logic               enable_q, enable_d;
   logic [NUM_REQ-1:0] mask_q, mask_d;
   logic               overflow_q, overflow_d;
   logic [DROP_W-1:0]  drop_cnt_q, drop_cnt_d;
   logic [DATA_W-1:0]  last_q, last_d;
   logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;

   // Bus decode
   reg_sel_e sel;
   logic     ctrl_wr, status_wr, cpu_push, flush_now;

   // Arbiter / push mux
   logic [NUM_REQ-1:0] eligible;
   logic [NUM_REQ-1:0] grant;
   logic               grant_any;
   logic [PTR_W-1:0]   grant_idx;
   logic [DATA_W-1:0]  grant_data;
   logic               fifo_push;
   logic [ENTRY_W-1:0] fifo_wdata;

   // FIFO
   logic [ENTRY_W-1:0] fifo_head;
   logic [CNT_W-1:0]   fifo_count;
   logic               fifo_full, fifo_empty;
   logic               fifo_pop;

   // Reads have no side effects, so the strobe carries no information here.
   logic unused_re;
   assign unused_re = re;

   assign sel       = decode_addr(address);
   assign ctrl_wr   = we && (sel == REG_CTRL);
   assign status_wr = we && (sel == REG_STATUS);
   assign cpu_push  = we && (sel == REG_PUSH);
   assign flush_now = ctrl_wr && write_data[CTRL_FLUSH_BIT];

   // ---------------------------------------------------------------- arbiter
   always_comb begin : arb_comb
      logic [PTR_W:0]   cand;
      logic [PTR_W-1:0] idx;
      cand      = '0;
      idx       = '0;
      grant_any = 1'b0;
      grant_idx = '0;
      grant     = '0;
      // CPU pushes, flushes and a full FIFO all suppress requester grants.
      eligible  = req_valid & mask_q & {NUM_REQ{enable_q}}
                & {NUM_REQ{~fifo_full & ~flush_now & ~cpu_push}};
      // Search from rr_ptr upward, wrapping once through all requesters.
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = {1'b0, rr_ptr_q} + PW1'(k);
         if (cand >= NREQ_W) begin
            cand = cand - NREQ_W;
         end
         idx = cand[PTR_W-1:0];
         if (!grant_any && eligible[idx]) begin
            grant_any = 1'b1;
            grant_idx = idx;
         end
      end
      if (grant_any) begin
         grant[grant_idx] = 1'b1;
      end
   end

   assign req_ready = grant;

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (grant_any) begin
         rr_ptr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
      end
   end

   // --------------------------------------------------------------- push mux
   always_comb begin
      grant_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            grant_data = req_data[DATA_W*i +: DATA_W];
         end
      end
   end

   always_comb begin
      fifo_push  = 1'b0;
      fifo_wdata = '0;
      if (cpu_push) begin
         fifo_push  = ~fifo_full;
         fifo_wdata = {CPU_SRC, write_data};
      end else if (grant_any) begin
         fifo_push  = 1'b1;
         fifo_wdata = {SRC_W'(grant_idx), grant_data};
      end
   end

   // ------------------------------------------------------------------- FIFO
   assign fifo_pop = trace_valid & trace_ready;

   debug_trace_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush_now),
      .push      (fifo_push),
      .push_data (fifo_wdata),
      .pop       (fifo_pop),
      .head_data (fifo_head),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Head is masked while empty so the outputs read 0 after reset or flush.
   assign trace_valid             = ~fifo_empty;
   assign {trace_src, trace_data} = fifo_empty ? '0 : fifo_head;
   assign irq_overflow            = overflow_q;

   // ---------------------------------------------------------- register file
   always_comb begin
      enable_d   = enable_q;
      mask_d     = mask_q;
      overflow_d = overflow_q;
      drop_cnt_d = drop_cnt_q;
      last_d     = last_q;
      if (ctrl_wr) begin
         enable_d = write_data[CTRL_EN_BIT];
         mask_d   = write_data[CTRL_MASK_LSB +: NUM_REQ];
      end
      if (status_wr) begin
         overflow_d = 1'b0;
         drop_cnt_d = '0;
      end
      if (cpu_push && fifo_full) begin
         overflow_d = 1'b1;
         if (drop_cnt_q != '1) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
         end
      end
      if (fifo_push) begin
         last_d = fifo_wdata[DATA_W-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         enable_q   <= 1'b0;
         mask_q     <= '0;
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
         last_q     <= '0;
         rr_ptr_q   <= '0;
      end else begin
         enable_q   <= enable_d;
         mask_q     <= mask_d;
         overflow_q <= overflow_d;
         drop_cnt_q <= drop_cnt_d;
         last_q     <= last_d;
         rr_ptr_q   <= rr_ptr_d;
      end
   end

   always_comb begin
      read_data = '0;
      case (sel)
         REG_CTRL: begin
            read_data[CTRL_EN_BIT]               = enable_q;
            read_data[CTRL_MASK_LSB +: NUM_REQ] = mask_q;
         end
         REG_STATUS: begin
            read_data[STAT_EMPTY_BIT]     = fifo_empty;
            read_data[STAT_FULL_BIT]      = fifo_full;
            read_data[STAT_OVF_BIT]       = overflow_q;
            read_data[STAT_CNT_LSB +: 8] = 8'(fifo_count);
         end
         REG_DROP: read_data[DROP_W-1:0] = drop_cnt_q;
         REG_LAST: read_data             = last_q;
         default:  read_data             = '0;
      endcase
   end

endmodule
